// File: rtl/mem_responder_if.sv
// Request/response bus between the fetch unit (master) and the wait-state memory (slave).
interface mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     MEM_REQ;
    logic                     MEM_WE;
    logic [ADDRESS_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0]    WD;
    logic [DATA_WIDTH-1:0]    RD;
    logic                     MEM_READY;
    logic                     MEM_BUSY;
    logic                     ADDR_ERR;

    modport master (
        output MEM_REQ, MEM_WE, Addr, WD,
        input  RD, MEM_READY, MEM_BUSY, ADDR_ERR
    );

    modport slave (
        input  MEM_REQ, MEM_WE, Addr, WD,
        output RD, MEM_READY, MEM_BUSY, ADDR_ERR
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM with a fixed wait-state latency; requests are captured in IDLE,
// counted down in BUSY and completed with a one-cycle RESP pulse.
module mem_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int WAIT_STATES   = 2
) (
    input logic            CLK,
    input logic            RST,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // One bit wider than the address so 4*DEPTH_WORDS never truncates.
    localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH+1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                   state, next_state;
    logic [3:0]               cnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wd_q;
    logic                     we_q;
    logic [DATA_WIDTH-1:0]    rd_q;
    logic                     err_q;
    logic                     complete;
    logic                     addr_bad;
    logic [IDX_W-1:0]         idx;

    logic [DATA_WIDTH-1:0]    mem [DEPTH_WORDS];

    assign complete = (state == BUSY) && (cnt == 4'd1);
    assign addr_bad = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= LIMIT);
    assign idx      = addr_q[IDX_W+1:2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.MEM_REQ) next_state = BUSY;
            BUSY:    if (complete)    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The access always uses the holding registers, so the bus inputs may move freely once accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            addr_q <= '0;
            wd_q   <= '0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else if (state == IDLE && bus.MEM_REQ) begin
            cnt    <= 4'(WAIT_STATES);
            addr_q <= bus.Addr;
            wd_q   <= bus.WD;
            we_q   <= bus.MEM_WE;
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
            if (complete) begin
                err_q <= addr_bad;
                if (addr_bad)   rd_q <= '0;
                else if (!we_q) rd_q <= mem[idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain; an asserted reset forces
    // state to IDLE, which already suppresses any pending write.
    always_ff @(posedge CLK) begin
        if (complete && we_q && !addr_bad) mem[idx] <= wd_q;
    end

    assign bus.RD        = rd_q;
    assign bus.MEM_READY = (state == RESP);
    assign bus.MEM_BUSY  = (state != IDLE);
    assign bus.ADDR_ERR  = (state == RESP) && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded random + directed bench for mem_responder.
module tb_mem_responder;
    localparam int AW = 32, DW = 32, DEPTH = 256, W = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_responder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    typedef struct {
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rd;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl[int];
    logic [DW-1:0] rd_mdl = '0;
    logic          rd_known = 1'b1;
    int vectors = 0, errors = 0, cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted access predicts one response, due W edges later.
    task automatic model(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d, input int acc);
        exp_t e;
        int   w;
        w     = int'(a >> 2);
        e.cyc = acc + W;
        if ((a % 4) != 0 || a >= AW'(4 * DEPTH)) begin
            rd_mdl   = '0;
            rd_known = 1'b1;
            e.err    = 1'b1;
        end else begin
            e.err = 1'b0;
            if (we) mdl[w] = d;
            else if (mdl.exists(w)) begin
                rd_mdl   = mdl[w];
                rd_known = 1'b1;
            end else rd_known = 1'b0;
        end
        e.rd     = rd_mdl;
        e.chk_rd = rd_known;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST) begin
            if (bus.MEM_READY) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("addr_err", 64'(bus.ADDR_ERR), 64'(e.err));
                    if (e.chk_rd) check("rd", 64'(bus.RD), 64'(e.rd));
                end
            end else begin
                check("err_without_ready", 64'(bus.ADDR_ERR), 64'd0);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.MEM_BUSY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (bus.MEM_BUSY) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic access(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d, input bit scramble);
        @(negedge CLK);
        bus.MEM_REQ = 1'b1;
        bus.MEM_WE  = we;
        bus.Addr    = a;
        bus.WD      = d;
        @(posedge CLK);
        @(negedge CLK);
        model(a, we, d, cyc);
        bus.MEM_REQ = 1'b0;
        if (scramble) begin
            // A second request and fresh inputs during BUSY must all be ignored.
            bus.MEM_REQ = 1'b1;
            bus.MEM_WE  = 1'($urandom);
            bus.Addr    = 32'h20;
            bus.WD      = $urandom;
            @(negedge CLK);
            bus.MEM_REQ = 1'b0;
            bus.Addr    = $urandom;
        end
        wait_idle("access");
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rd"},    64'(bus.RD),        64'd0);
        check({tag, "_ready"}, 64'(bus.MEM_READY), 64'd0);
        check({tag, "_busy"},  64'(bus.MEM_BUSY),  64'd0);
        check({tag, "_err"},   64'(bus.ADDR_ERR),  64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc, busy_cnt, r;
        logic [AW-1:0] a;
        bus.MEM_REQ = 1'b0;
        bus.MEM_WE  = 1'b0;
        bus.Addr    = '0;
        bus.WD      = '0;
        #1 reset_checks("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Write-then-read, input change mid-access
        access(32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
        access(32'h10, 1'b0, '0, 1'b0);
        access(32'h0,  1'b1, 32'h11110000, 1'b0);
        access(32'h20, 1'b1, 32'h55555555, 1'b0);
        access(32'h10, 1'b0, '0, 1'b1);

        // Error accesses must leave storage untouched (0x13 aliases word 4, 0x400 aliases word 0)
        access(32'h13,  1'b1, 32'h12345678, 1'b0);
        access(32'h400, 1'b1, 32'h12345678, 1'b0);
        access(32'h13,  1'b0, '0, 1'b0);
        access(32'h10,  1'b0, '0, 1'b0);
        access(32'h0,   1'b0, '0, 1'b0);

        // Top word of storage
        access(32'h3FC, 1'b1, 32'hCAFEF00D, 1'b0);
        access(32'h3FC, 1'b0, '0, 1'b0);

        // MEM_REQ held high: accepts every W+2 cycles, busy W+1 of them
        @(negedge CLK);
        bus.MEM_REQ = 1'b1;
        bus.MEM_WE  = 1'b0;
        bus.Addr    = 32'h20;
        @(posedge CLK);
        @(negedge CLK);
        acc = cyc;
        for (int j = 0; j < 3; j++) model(32'h20, 1'b0, '0, acc + j * (W + 2));
        busy_cnt = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            if (i > 0) @(negedge CLK);
            if (bus.MEM_BUSY) busy_cnt++;
            if (i == 2 * (W + 2)) bus.MEM_REQ = 1'b0;
        end
        check("busy_duty", 64'(busy_cnt), 64'(3 * (W + 1)));
        wait_idle("held_req");

        // Reset one cycle into a write aborts it
        access(32'h40, 1'b1, 32'h0BADF00D, 1'b0);
        access(32'h40, 1'b0, '0, 1'b0);
        @(negedge CLK);
        bus.MEM_REQ = 1'b1;
        bus.MEM_WE  = 1'b1;
        bus.Addr    = 32'h40;
        bus.WD      = 32'hAAAA5555;
        @(posedge CLK);
        @(negedge CLK);
        bus.MEM_REQ = 1'b0;
        RST = 1'b1;
        #1 reset_checks("async_rst");
        rd_mdl   = '0;
        rd_known = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        access(32'h40, 1'b0, '0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = AW'($urandom_range(0, 15) * 4);
            else if (r == 6) a = AW'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 7) a = AW'($urandom_range(0, 4 * DEPTH - 1)) | AW'($urandom_range(1, 3));
            else if (r == 8) a = $urandom;
            else             a = 32'h3FC;
            access(a, 1'($urandom), $urandom, 1'($urandom));
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
